// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle MIPS sequencer emitting per-step datapath enables,
// with free-run/single-step control, retired-instruction count and sticky illegal-opcode halt.
module mips_mc_control #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               run_i,
    input  logic               step_i,
    input  logic [5:0]         opcode_i,
    input  logic [5:0]         funct_i,
    input  logic               zero_i,
    output logic               pc_write_o,
    output logic [1:0]         pc_src_o,
    output logic               ir_write_o,
    output logic               reg_write_o,
    output logic               reg_dst_o,
    output logic               alu_src_o,
    output logic [1:0]         alu_sel_o,
    output logic [5:0]         alu_funct_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               mem_to_reg_o,
    output logic               instr_done_o,
    output logic               halted_o,
    output logic [2:0]         state_o,
    output logic [COUNT_W-1:0] retired_o
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
        MEM = 3'd4, WB = 3'd5, HALT = 3'd7
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02;

    state_t               state_q, state_d;
    logic                 halted_q;
    logic                 step_q;
    logic [COUNT_W-1:0]   retired_q;
    logic                 step_edge, legal, taken;
    state_t               end_state;

    assign step_edge = step_i & ~step_q;
    assign legal     = opcode_i inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    assign taken     = (opcode_i == OP_BEQ) ? zero_i : ~zero_i;
    assign end_state = run_i ? FETCH : IDLE;
    assign halted_o  = halted_q;
    assign state_o   = state_q;
    assign retired_o = retired_q;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            halted_q  <= 1'b0;
            step_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_q | (state_d == HALT);
            step_q    <= step_i;
            retired_q <= retired_q + COUNT_W'(instr_done_o);
        end
    end

    // Everything is decoded only while out of reset, so no enable leaks during a reset cycle.
    always_comb begin
        state_d      = state_q;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        alu_src_o    = 1'b0;
        alu_sel_o    = 2'b00;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        instr_done_o = 1'b0;
        if (reset_i) begin
            case (state_q)
                IDLE: if (run_i || step_edge) state_d = FETCH;
                FETCH: begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = DECODE;
                end
                DECODE: begin
                    if (!legal) begin
                        state_d = HALT;
                    end else if (opcode_i == OP_J) begin
                        pc_write_o   = 1'b1;
                        pc_src_o     = 2'b10;
                        instr_done_o = 1'b1;
                        state_d      = end_state;
                    end else begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    case (opcode_i)
                        OP_R: begin
                            alu_sel_o = 2'b10;
                            state_d   = WB;
                        end
                        OP_ADDI: begin
                            alu_src_o = 1'b1;
                            state_d   = WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_src_o = 1'b1;
                            state_d   = MEM;
                        end
                        OP_BEQ, OP_BNE: begin
                            alu_sel_o    = 2'b01;
                            instr_done_o = 1'b1;
                            pc_write_o   = taken;
                            pc_src_o     = taken ? 2'b01 : 2'b00;
                            state_d      = end_state;
                        end
                        default: state_d = HALT;
                    endcase
                end
                MEM: begin
                    if (opcode_i == OP_LW) begin
                        mem_read_o = 1'b1;
                        alu_src_o  = 1'b1;
                        state_d    = WB;
                    end else if (opcode_i == OP_SW) begin
                        mem_write_o  = 1'b1;
                        alu_src_o    = 1'b1;
                        instr_done_o = 1'b1;
                        state_d      = end_state;
                    end else begin
                        state_d = HALT;
                    end
                end
                WB: begin
                    if (opcode_i inside {OP_R, OP_ADDI, OP_LW}) begin
                        reg_write_o  = 1'b1;
                        reg_dst_o    = (opcode_i == OP_R);
                        alu_src_o    = (opcode_i != OP_R);
                        mem_read_o   = (opcode_i == OP_LW);
                        mem_to_reg_o = (opcode_i == OP_LW);
                        instr_done_o = 1'b1;
                        state_d      = end_state;
                    end else begin
                        state_d = HALT;
                    end
                end
                HALT: state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
        alu_funct_o = (alu_sel_o == 2'b10) ? funct_i : 6'd0;
    end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: instruction-level reference model plus directed literal checks
// and randomized run/step/opcode/reset stimulus for the multi-cycle controller.
module tb_mips_mc_control;
    localparam logic [5:0] R = 6'h00, ADDI = 6'h08, LW = 6'h23, SW = 6'h2B;
    localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, J = 6'h02, ILL = 6'h3F;

    logic clock = 1'b0;
    logic rst_n = 1'b0, run = 1'b0, step = 1'b0, zero = 1'b0;
    logic [5:0] opcode = 6'h00, funct = 6'h00;

    logic pc_write, ir_write, reg_write, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, instr_done, halted;
    logic [1:0] pc_src, alu_sel;
    logic [5:0] alu_funct;
    logic [2:0] state;
    logic [15:0] retired;

    logic b_pc_write, b_ir_write, b_reg_write, b_reg_dst, b_alu_src, b_mem_read, b_mem_write, b_mem_to_reg, b_instr_done, b_halted;
    logic [1:0] b_pc_src, b_alu_sel;
    logic [5:0] b_alu_funct;
    logic [2:0] b_state;
    logic [1:0] retired2;

    always #5 clock = ~clock;

    mips_mc_control dut (
        .clock_i(clock), .reset_i(rst_n), .run_i(run), .step_i(step), .opcode_i(opcode),
        .funct_i(funct), .zero_i(zero), .pc_write_o(pc_write), .pc_src_o(pc_src),
        .ir_write_o(ir_write), .reg_write_o(reg_write), .reg_dst_o(reg_dst), .alu_src_o(alu_src),
        .alu_sel_o(alu_sel), .alu_funct_o(alu_funct), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_to_reg_o(mem_to_reg), .instr_done_o(instr_done), .halted_o(halted), .state_o(state),
        .retired_o(retired)
    );

    mips_mc_control #(.COUNT_W(2)) dut2 (
        .clock_i(clock), .reset_i(rst_n), .run_i(run), .step_i(step), .opcode_i(opcode),
        .funct_i(funct), .zero_i(zero), .pc_write_o(b_pc_write), .pc_src_o(b_pc_src),
        .ir_write_o(b_ir_write), .reg_write_o(b_reg_write), .reg_dst_o(b_reg_dst), .alu_src_o(b_alu_src),
        .alu_sel_o(b_alu_sel), .alu_funct_o(b_alu_funct), .mem_read_o(b_mem_read), .mem_write_o(b_mem_write),
        .mem_to_reg_o(b_mem_to_reg), .instr_done_o(b_instr_done), .halted_o(b_halted), .state_o(b_state),
        .retired_o(retired2)
    );

    int checks = 0, errors = 0;
    bit m_valid = 0, m_halt = 0, m_busy = 0, m_sp = 0;
    int m_k = 0, m_ret = 0;

    logic [18:0] seen_ctrl;
    logic [2:0]  seen_state;
    logic        seen_halted;
    logic [15:0] seen_retired;
    logic [1:0]  seen_retired2;

    function automatic bit is_legal(logic [5:0] op);
        return op == R || op == ADDI || op == LW || op == SW || op == BEQ || op == BNE || op == J;
    endfunction

    function automatic int instr_len(logic [5:0] op);
        if (!is_legal(op)) return 2;
        if (op == J) return 2;
        if (op == BEQ || op == BNE) return 3;
        if (op == LW) return 5;
        return 4;
    endfunction

    // Step k of an instruction: fetch, decode, execute, then memory for loads/stores, then write-back.
    function automatic int step_state(logic [5:0] op, int k);
        if (k < 3) return k + 1;
        if (k == 3) return (op == LW || op == SW) ? 4 : 5;
        return 5;
    endfunction

    function automatic logic [18:0] exp_ctrl(int st, logic [5:0] op, logic z, logic [5:0] fn);
        logic pw = 0, ir = 0, rw = 0, rd = 0, as = 0, mr = 0, mw = 0, m2r = 0, dn = 0;
        logic [1:0] ps = 0, al = 0;
        logic [5:0] af;
        if (st == 1) begin ir = 1; pw = 1; end
        if (st == 2 && op == J) begin pw = 1; ps = 2; dn = 1; end
        if (st == 3) begin
            if (op == R) al = 2;
            if (op == ADDI || op == LW || op == SW) as = 1;
            if (op == BEQ || op == BNE) begin
                al = 1; dn = 1;
                if ((op == BEQ && z) || (op == BNE && !z)) begin pw = 1; ps = 1; end
            end
        end
        if (st == 4) begin as = 1; if (op == LW) mr = 1; else begin mw = 1; dn = 1; end end
        if (st == 5) begin rw = 1; dn = 1; rd = (op == R); as = (op != R); mr = (op == LW); m2r = (op == LW); end
        af = (al == 2) ? fn : 6'd0;
        return {pw, ps, ir, rw, rd, as, al, af, mr, mw, m2r, dn};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic r_n, input logic r, input logic s, input logic [5:0] op, input logic z);
        int st;
        bit edge_seen;
        @(negedge clock);
        rst_n = r_n; run = r; step = s; opcode = op; zero = z; funct = 6'($urandom);
        #1;
        seen_ctrl = {pc_write, pc_src, ir_write, reg_write, reg_dst, alu_src, alu_sel, alu_funct,
                     mem_read, mem_write, mem_to_reg, instr_done};
        seen_state = state; seen_halted = halted; seen_retired = retired; seen_retired2 = retired2;
        if (m_valid) begin
            st = m_halt ? 7 : (m_busy ? step_state(op, m_k) : 0);
            chk("state", 32'(state), 32'(st));
            chk("halted", 32'(halted), 32'(m_halt));
            chk("retired", 32'(retired), 32'(m_ret & 16'hFFFF));
            chk("retired_w2", 32'(retired2), 32'(m_ret & 3));
            chk("ctrl", 32'(seen_ctrl), 32'(r_n ? exp_ctrl(st, op, z, funct) : 19'd0));
        end
        @(posedge clock);
        if (!r_n) begin
            m_valid = 1; m_halt = 0; m_busy = 0; m_k = 0; m_ret = 0; m_sp = 0;
        end else begin
            edge_seen = s && !m_sp;
            m_sp = s;
            if (m_halt) begin
            end else if (!m_busy) begin
                if (r || edge_seen) begin m_busy = 1; m_k = 0; end
            end else if (m_k == 1 && !is_legal(op)) begin
                m_halt = 1; m_busy = 0;
            end else if (m_k == instr_len(op) - 1) begin
                m_ret++; m_busy = r; m_k = 0;
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic branch(input logic [5:0] op, input logic z, input logic exp_pw);
        tick(1, 0, 0, op, z);
        tick(1, 0, 1, op, z);
        tick(1, 0, 1, op, z);
        tick(1, 0, 1, op, z);
        tick(1, 0, 1, op, z);
        chk("br_state", 32'(seen_state), 32'd3);
        chk("br_pc_write", 32'(seen_ctrl[18]), 32'(exp_pw));
        chk("br_pc_src", 32'(seen_ctrl[17:16]), exp_pw ? 32'd1 : 32'd0);
        chk("br_done", 32'(seen_ctrl[0]), 32'd1);
        tick(1, 0, 0, op, z);
        chk("br_idle", 32'(seen_state), 32'd0);
    endtask

    int tr[18] = '{1,2,3,5, 1,2,3,4,5, 1,2,3,4, 1,2,3, 1,2};
    logic [5:0] tr_op[18] = '{R,R,R,R, LW,LW,LW,LW,LW, SW,SW,SW,SW, BEQ,BEQ,BEQ, J,J};
    logic [5:0] legal_ops[7] = '{R, ADDI, LW, SW, BEQ, BNE, J};

    initial begin
        int busy_cycles;
        logic [5:0] rop;
        tick(0, 0, 0, R, 0);
        tick(0, 0, 0, R, 0);
        tick(1, 0, 0, R, 0);
        chk("rst_state", 32'(seen_state), 32'd0);
        chk("rst_retired", 32'(seen_retired), 32'd0);
        chk("rst_halted", 32'(seen_halted), 32'd0);

        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 1, ADDI, 0);
            if (seen_state != 3'd0) busy_cycles++;
        end
        chk("step_cycles", 32'(busy_cycles), 32'd4);
        tick(1, 0, 0, ADDI, 0);
        chk("step_retired", 32'(seen_retired), 32'd1);
        chk("step_idle", 32'(seen_state), 32'd0);

        tick(0, 0, 0, R, 0);
        tick(1, 1, 0, R, 0);
        for (int i = 0; i < 18; i++) begin
            tick(1, 1, 0, tr_op[i], 0);
            chk("trace", 32'(seen_state), 32'(tr[i]));
        end
        tick(1, 0, 0, R, 0);
        chk("trace_retired", 32'(seen_retired), 32'd5);

        tick(0, 0, 0, LW, 0);
        tick(1, 1, 0, LW, 0);
        tick(1, 1, 0, LW, 0);
        tick(1, 1, 0, LW, 0);
        tick(1, 1, 0, LW, 0);
        tick(0, 1, 0, LW, 0);
        chk("midlw_state", 32'(seen_state), 32'd4);
        chk("midlw_mem_read", 32'(seen_ctrl[3]), 32'd0);
        chk("midlw_reg_write", 32'(seen_ctrl[14]), 32'd0);
        tick(1, 0, 0, LW, 0);
        chk("midlw_after", 32'(seen_state), 32'd0);
        chk("midlw_retired", 32'(seen_retired), 32'd0);
        chk("midlw_after_rw", 32'(seen_ctrl[14]), 32'd0);

        branch(BEQ, 1, 1);
        branch(BEQ, 0, 0);
        branch(BNE, 0, 1);
        branch(BNE, 1, 0);

        tick(1, 0, 0, ILL, 0);
        tick(1, 0, 1, ILL, 0);
        tick(1, 0, 1, ILL, 0);
        tick(1, 0, 1, ILL, 0);
        chk("ill_decode", 32'(seen_state), 32'd2);
        for (int i = 0; i < 6; i++) begin
            tick(1, i[0], i[1], (i > 2) ? R : ILL, 0);
            chk("halt_state", 32'(seen_state), 32'd7);
            chk("halt_flag", 32'(seen_halted), 32'd1);
            chk("halt_ctrl", 32'(seen_ctrl), 32'd0);
        end
        tick(0, 0, 0, R, 0);
        tick(1, 0, 0, R, 0);
        chk("halt_cleared", 32'(seen_halted), 32'd0);
        chk("halt_cleared_st", 32'(seen_state), 32'd0);

        tick(0, 0, 0, J, 0);
        for (int i = 0; i < 11; i++) tick(1, 1, 0, J, 0);
        tick(1, 0, 0, J, 0);
        chk("wrap_w2", 32'(seen_retired2), 32'd1);
        chk("wrap_w16", 32'(seen_retired), 32'd5);

        rop = R;
        for (int i = 0; i < 4000; i++) begin
            if (m_halt || !m_busy || m_k == 0)
                rop = ($urandom % 25 == 0) ? 6'($urandom) : legal_ops[$urandom % 7];
            tick(($urandom % 150) != 0, ($urandom % 8) < 5, ($urandom % 3) == 0, rop, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle sequencing controller for the MIPS datapath. It replaces single-cycle decode with a state machine that splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps and emits one-cycle enables for PC, instruction register, register file, ALU and data memory. It supports free-run and single-step execution, counts retired instructions, and halts on an illegal opcode.

## Interface
- COUNT_W, 16, width of the retired-instruction counter
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block
- run  in  1  1 = free-run; 0 = single-step mode
- step  in  1  step request; only its rising edge is used, via an internal 1-cycle-delayed copy
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]; passed through for R-type
- zero  in  1  ALU result == 0
- pc_write  out  1  load PC this cycle
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- ir_write  out  1  load instruction register
- reg_write  out  1  register-file write enable
- reg_dst  out  1  1 = rd [15:11], 0 = rt [20:16]
- alu_src  out  1  1 = sign-extended immediate, 0 = rt data
- alu_sel  out  2  00 = add, 01 = sub, 10 = funct-defined
- alu_funct  out  6  equals funct when alu_sel = 10, else 0
- mem_read  out  1  data-memory read
- mem_write  out  1  data-memory write
- mem_to_reg  out  1  write-back from memory
- instr_done  out  1  1-cycle pulse in an instruction's last cycle
- halted  out  1  sticky illegal-opcode flag
- state  out  3  current state, for debug
- retired  out  COUNT_W  retired-instruction count

## Operation
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 7.
- Legal opcodes: R = 0x00, ADDI = 0x08, LW = 0x23, SW = 0x2B, BEQ = 0x04, BNE = 0x05, J = 0x02.
- Any other opcode seen in DECODE moves to HALT and sets halted. HALT asserts no enables and is left only by reset.
- IDLE:
  - run = 1 → FETCH.
  - step rising edge → FETCH.
  - otherwise stay in IDLE.
- FETCH: ir_write = 1, pc_write = 1, pc_src = 00 → DECODE.
- DECODE:
  - J: pc_write = 1, pc_src = 10, instr_done = 1 → end.
  - Any other legal opcode → EXEC.
  - Illegal opcode → HALT.
- EXEC:
  - R: alu_sel = 10 → WB.
  - ADDI: alu_src = 1, alu_sel = 00 → WB.
  - LW and SW: alu_src = 1, alu_sel = 00 → MEM.
  - BEQ and BNE: alu_sel = 01, instr_done = 1 → end. pc_write = 1 and pc_src = 01 only if taken; taken means zero = 1 for BEQ, zero = 0 for BNE.
- MEM:
  - LW: mem_read = 1, alu_src = 1 → WB.
  - SW: mem_write = 1, alu_src = 1, instr_done = 1 → end.
- WB:
  - R: reg_write = 1, reg_dst = 1.
  - ADDI: reg_write = 1, reg_dst = 0, alu_src = 1.
  - LW: reg_write = 1, mem_to_reg = 1, mem_read = 1, alu_src = 1.
  - All cases: instr_done = 1 → end.
- "End" means the next state is FETCH if run = 1, else IDLE.
- Cycles per instruction: J 2, BEQ/BNE 3, R/ADDI/SW 4, LW 5.
- Any output not listed for a state/opcode is 0.
- retired increments by 1 on each instr_done and wraps modulo 2^COUNT_W.

## Timing
- Outputs are combinational from the state register, opcode and zero. They are valid within the state's cycle and act at the next rising edge.
- Reset (reset = 0 at an edge):
  - state → IDLE, halted → 0, retired → 0, step history → 0.
  - While reset = 0, all enables and instr_done are forced to 0, including mid-instruction. No partial write escapes.
- Step edges:
  - A step edge while not in IDLE is ignored, not queued.
  - Holding step high gives exactly one instruction.
  - run = 1 together with a step edge behaves as run alone.
- Clearing run mid-instruction completes the current instruction, then goes to IDLE.
- Each enable pulses for exactly one cycle per use. mem_read spans MEM and WB for LW.

## Test plan
- Reset mid-LW (drop reset in MEM) → next cycle state = 0; reg_write, mem_read and retired stay 0 through the reset cycle and afterwards.
- run = 0, hold step high for 10 cycles with an ADDI opcode → exactly one FETCH..WB sequence (4 cycles), retired = 1, then IDLE.
- run = 1 with opcodes R, LW, SW, BEQ, J in sequence → state traces 1-2-3-5, 1-2-3-4-5, 1-2-3-4, 1-2-3, 1-2; 18 cycles; retired = 5.
- Branch polarity:
  - BEQ with zero = 1 → pc_write = 1, pc_src = 01 in EXEC.
  - BEQ with zero = 0 → pc_write = 0.
  - BNE gives the inverse.
- Opcode 0x3F in DECODE → state = 7, halted = 1; no enables afterwards under run or step; reset clears halted.
- COUNT_W = 2, retire 5 instructions → retired = 1 (wrap).
